// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default parameters for the multi-port register file.
//   clr_state_e    - clear sequencer states (IDLE, CLEAR)
//   *_DEF          - default values for DATA_W, ADDR_W, NUM_RD, DBG_IDX
package regfile_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned NUM_RD_DEF  = 2;
    localparam int unsigned DBG_IDX_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: request/response bundle of the multi-port register file.
//   clr_req  - one-cycle request to clear every entry
//   wr_en/wr_addr/wr_data - single write port
//   rd_addr  - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  - packed read data, port k at [k*DATA_W +: DATA_W]
//   dbg_data - contents of the debug entry
//   busy     - clear sequence in progress
//   wr_drop  - asserted write is being discarded
// Modports: master (requester side), slave (register file side).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
) ();

    logic                     clr_req;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]        dbg_data;
    logic                     busy;
    logic                     wr_drop;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, dbg_data, busy, wr_drop
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, dbg_data, busy, wr_drop
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequencer that zeroes entries 1..DEPTH-1, one per cycle.
//   clk     - clock
//   rst     - synchronous active-high reset; forces CLEAR with clr_ptr=1
//   clr_req - start a clear (ignored while already clearing)
//   busy    - registered, high while in CLEAR
//   clr_ptr - entry being zeroed this cycle
//   clr_we  - registered clear write strobe
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_ptr,
    output logic              clr_we
);

    clr_state_e state;

    // Entry 0 is hardwired to zero, so the sweep runs 1..DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= ADDR_W'(1);
            busy    <= 1'b1;
            clr_we  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= ADDR_W'(1);
                        busy    <= 1'b1;
                        clr_we  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == '1) begin
                        state   <= IDLE;
                        clr_ptr <= ADDR_W'(1);
                        busy    <= 1'b0;
                        clr_we  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with one write port, NUM_RD combinational read
// ports, a debug tap on entry DBG_IDX and a sequenced clear.
//   clk     - clock
//   myreset - synchronous active-high reset; starts a full clear
//   bus     - regfile_mp_if.slave (write, reads, clear request, status)
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_RD  = NUM_RD_DEF,
    parameter int unsigned DBG_IDX = DBG_IDX_DEF
) (
    input  logic         clk,
    input  logic         myreset,
    regfile_mp_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     busy;
    logic [ADDR_W-1:0]        clr_ptr;
    logic                     clr_we;
    logic                     wr_ok_c;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk     (clk),
        .rst     (myreset),
        .clr_req (bus.clr_req),
        .busy    (busy),
        .clr_ptr (clr_ptr),
        .clr_we  (clr_we)
    );

    // A write lands only when idle and not colliding with a clear request.
    assign wr_ok_c     = bus.wr_en && (bus.wr_addr != '0) && !busy && !bus.clr_req;
    assign bus.wr_drop = bus.wr_en && (bus.wr_addr != '0) && (busy || bus.clr_req);
    assign bus.busy    = busy;

    // Storage update; entry 0 is never written and reads are masked instead.
    always_ff @(posedge clk) begin
        if (!myreset) begin
            if (clr_we) begin
                mem[clr_ptr] <= '0;
            end else if (wr_ok_c) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Read one entry as seen from outside: zero while clearing or for entry 0.
    function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (busy || (a == '0)) begin
            v = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_ok_c && (a == bus.wr_addr)) begin
            v = bus.wr_data;
        end
`endif
        else begin
            v = mem[a];
        end
        return v;
    endfunction

    // Independent read ports.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_data_c[k*DATA_W +: DATA_W] = read_entry(bus.rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.dbg_data = read_entry(ADDR_W'(DBG_IDX));

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: bit width of each register entry.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, legal range 1..4.
REQ-004 Parameter DBG_IDX, default 2: entry index continuously exposed on dbg_data.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port myreset, input, 1: synchronous, active-high reset.
REQ-007 Port clr_req, input, 1: one-cycle request to clear all entries.
REQ-008 Port wr_en, input, 1: write enable.
REQ-009 Port wr_addr, input, ADDR_W: write address.
REQ-010 Port wr_data, input, DATA_W: write data.
REQ-011 Port rd_addr, input, NUM_RD*ADDR_W: packed read addresses; port k occupies slice [k*ADDR_W +: ADDR_W].
REQ-012 Port rd_data, output, NUM_RD*DATA_W: packed read data; port k occupies slice [k*DATA_W +: DATA_W].
REQ-013 Port dbg_data, output, DATA_W: contents of entry DBG_IDX.
REQ-014 Port busy, output, 1: high while a clear sequence is in progress.
REQ-015 Port wr_drop, output, 1: combinational flag; high when an asserted wr_en is being discarded.

Function
REQ-016 Read path SHALL be combinational; rd_data for port k SHALL reflect entry rd_addr[k] in the same cycle.
REQ-017 Entry 0 SHALL read as zero at all times; a write to address 0 SHALL be ignored and SHALL NOT raise wr_drop.
REQ-018 In IDLE, a write with wr_en=1, wr_addr!=0 and clr_req=0 SHALL update the entry at the next rising edge.
REQ-019 The FSM SHALL have two states, IDLE and CLEAR, with a clear pointer clr_ptr of ADDR_W bits.
REQ-020 IDLE to CLEAR: on clr_req=1 in IDLE, set clr_ptr to 1 at the next edge.
REQ-021 In CLEAR, each cycle SHALL write 0 to entry clr_ptr and increment clr_ptr; when clr_ptr equals DEPTH-1, that cycle SHALL write the last entry and the FSM SHALL return to IDLE. A clear SHALL therefore take exactly DEPTH-1 cycles.
REQ-022 busy SHALL equal (state==CLEAR).
REQ-023 While busy=1, every rd_data port and dbg_data SHALL read 0, regardless of stored contents.
REQ-024 wr_drop SHALL equal wr_en AND (wr_addr!=0) AND (busy OR clr_req); a dropped write SHALL NOT modify any entry.
REQ-025 clr_req while in CLEAR SHALL be ignored; the sequence SHALL NOT restart.
REQ-026 Read ports SHALL be fully independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-027 myreset=1 at a rising edge SHALL force state CLEAR and clr_ptr=1, overriding clr_req and wr_en.
REQ-028 While myreset stays high, the FSM SHALL hold CLEAR with clr_ptr=1; busy=1, rd_data=0, dbg_data=0.
REQ-029 After myreset is released, the full DEPTH-1 cycle clear SHALL run before busy falls.
REQ-030 myreset asserted during a clear in progress SHALL restart the clear from clr_ptr=1.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: when busy=0, wr_en=1, wr_addr!=0, clr_req=0 and rd_addr[k]==wr_addr, rd_data[k] SHALL return wr_data in the same cycle. The same rule SHALL apply to dbg_data when wr_addr==DBG_IDX.
REQ-032 Macro REGFILE_BYPASS_EN undefined: reads SHALL return stored contents only; written data SHALL become visible the cycle after the write edge.

Structure
REQ-033 Package regfile_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default parameter constants.
REQ-034 The clear sequencer SHALL be a single sub-module, regfile_clr_fsm, that outputs busy, clr_ptr and the clear write strobe.

Verification (DATA_W=32, ADDR_W=5, NUM_RD=2)
REQ-035 Pulse myreset for 1 cycle -> busy=1 for exactly 31 cycles, rd_data=0 throughout; all entries read 0 afterwards.
REQ-036 Write 0xDEADBEEF to entry 5, then read entry 5 on both ports -> both return 0xDEADBEEF; dbg_data=0.
REQ-037 Write 0x12345678 to entry 2 and read entry 2 in the same cycle -> with bypass, 0x12345678 immediately; without bypass, the old value, then 0x12345678 next cycle.
REQ-038 Write 0xFFFFFFFF to entry 0 -> entry 0 reads 0 and wr_drop=0.
REQ-039 clr_req and a write to entry 7 in the same cycle -> wr_drop=1, busy=1 for 31 cycles, entry 7 reads 0 afterwards.
REQ-040 myreset asserted at clr_ptr=10 during a clear -> clear restarts at 1 and busy stays high for 31 cycles after myreset falls.
